// File: rtl/ram_update_ctrl.sv
// ram_update_ctrl
//   Update-side writer/reader for the 267-bit x 16-entry lookup-table RAM.
//   32-bit command words arrive on a valid/ready stream; write commands are
//   assembled into a full entry and written in one strobe, read commands
//   fetch an entry and return it as nine 32-bit response words.
//
// Ports
//   axi_clk, axi_rst          clock, synchronous active-high reset
//   s_cmd_valid/ready/data/last  command word stream (header + data words)
//   m_rsp_valid/ready/data/last  read-back response stream (9 words)
//   ram_wr_en/addr/data       RAM update-side write port
//   ram_rd_en/addr, ram_rd_data  RAM update-side read port (1-cycle latency)
//   busy                      high whenever the FSM is not idle
//   err_cnt                   saturating count of malformed commands
module ram_update_ctrl #(
  parameter int ENTRY_W = 267,
  parameter int WORDS   = 9
) (
  input  logic               axi_clk,
  input  logic               axi_rst,
  input  logic               s_cmd_valid,
  output logic               s_cmd_ready,
  input  logic [31:0]        s_cmd_data,
  input  logic               s_cmd_last,
  output logic               m_rsp_valid,
  input  logic               m_rsp_ready,
  output logic [31:0]        m_rsp_data,
  output logic               m_rsp_last,
  output logic               ram_wr_en,
  output logic [3:0]         ram_wr_addr,
  output logic [ENTRY_W-1:0] ram_wr_data,
  output logic               ram_rd_en,
  output logic [3:0]         ram_rd_addr,
  input  logic [ENTRY_W-1:0] ram_rd_data,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  localparam int         SHADOW_W = WORDS * 32;
  localparam int         PAD_W    = SHADOW_W - ENTRY_W;       // unused bits above the entry
  localparam int         LAST_W   = ENTRY_W - 32 * (WORDS - 1); // live bits of the final word
  localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    RD_REQ,
    RD_WAIT,
    RESP,
    DRAIN
  } state_t;

  state_t                  state, next_state;
  logic [3:0]              cnt;
  logic [3:0]              addr;
  logic [WORDS-1:0][31:0]  shadow;
  logic [7:0]              err_q;
  logic                    run;      // low until the first edge after reset
  logic                    out_en;
  logic                    err_inc;
  logic                    cmd_fire;
  logic                    rsp_fire;
  logic [1:0]              opcode;

  // Outputs stay at zero during reset and on the first edge after it, so the
  // parser never sees ready before the block has left reset cleanly.
  assign out_en   = run && !axi_rst;
  assign cmd_fire = s_cmd_valid && s_cmd_ready;
  assign rsp_fire = m_rsp_valid && m_rsp_ready;
  assign opcode   = s_cmd_data[31:30];

  // Output decode: everything is a function of the registered state.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    s_cmd_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    m_rsp_last  = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    busy        = 1'b0;
    err_cnt     = '0;
    if (out_en) begin
      busy    = (state != IDLE);
      err_cnt = err_q;
      case (state)
        IDLE, COLLECT, DRAIN: s_cmd_ready = 1'b1;
        WRITE: begin
          ram_wr_en   = 1'b1;
          ram_wr_addr = addr;
          ram_wr_data = ENTRY_W'(shadow);
        end
        RD_REQ: begin
          ram_rd_en   = 1'b1;
          ram_rd_addr = addr;
        end
        RESP: begin
          // Pad bits above the entry are always zero, so word 8 comes out
          // zero-extended without extra muxing.
          m_rsp_valid = 1'b1;
          m_rsp_data  = shadow[cnt];
          m_rsp_last  = (cnt == LAST_IDX);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    err_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (opcode == OP_WRITE && !s_cmd_last)     next_state = COLLECT;
          else if (opcode == OP_READ && s_cmd_last)  next_state = RD_REQ;
          else if (!s_cmd_last)                      next_state = DRAIN;
          else                                       err_inc    = 1'b1;
        end
      end
      COLLECT: begin
        if (cmd_fire) begin
          if (s_cmd_last) begin
            if (cnt == LAST_IDX) begin
              next_state = WRITE;
            end else begin
              err_inc    = 1'b1;
              next_state = IDLE;
            end
          end else if (cnt == LAST_IDX) begin
            // Overlong write: the error is counted once, when the drain
            // reaches the command's last word.
            next_state = DRAIN;
          end
        end
      end
      WRITE:   next_state = IDLE;
      RD_REQ:  next_state = RD_WAIT;
      RD_WAIT: next_state = RESP;
      RESP: begin
        if (rsp_fire && cnt == LAST_IDX) next_state = IDLE;
      end
      DRAIN: begin
        if (cmd_fire && s_cmd_last) begin
          err_inc    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr   <= '0;
      // NOTE: the shadow is a plain register bank rather than a RAM, so it
      // takes the reset; this also pins the pad bits above the entry at zero.
      shadow <= '0;
      err_q  <= '0;
      run    <= 1'b0;
    end else begin
      state <= next_state;
      run   <= 1'b1;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            addr <= s_cmd_data[3:0];
            cnt  <= '0;
          end
        end
        COLLECT: begin
          if (cmd_fire) begin
            if (cnt == LAST_IDX)
              shadow[cnt] <= {{(32-LAST_W){1'b0}}, s_cmd_data[LAST_W-1:0]};
            else
              shadow[cnt] <= s_cmd_data;
            cnt <= cnt + 4'd1;
          end
        end
        RD_WAIT: begin
          shadow <= {{PAD_W{1'b0}}, ram_rd_data};
          cnt    <= '0;
        end
        RESP: begin
          if (rsp_fire) cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
